majority_filter: RTL
====================

// Module: majority_filter
// PURPOSE
//  Multi-channel sliding-window majority voter with optional hysteresis.
//  Generalises the fixed 5-of-8 combinational vote to CHANNELS independent
//  serial inputs, each filtered over the last WINDOW qualified samples.
//  Sits behind the oversampling stage of the serial receivers and feeds
//  clean bit decisions plus edge strobes to the framing logic.
// PARAMETERS
//  CHANNELS   1   number of independent input lanes
//  WINDOW     8   samples per vote window (2..64)
//  THRESH_HI  5   count >= THRESH_HI drives decision high
//  THRESH_LO  3   with HYSTERESIS=1: count <= THRESH_LO drives decision low
//  HYSTERESIS 0   0: pure threshold on THRESH_HI; 1: two-level hysteresis
// PORTS
//  clk        in   1         sole clock, rising edge
//  reset      in   1         synchronous, active-high
//  clear      in   1         synchronous window flush, same effect as reset
//  sample_en  in   1         qualifies din this cycle (oversample strobe)
//  din        in   CHANNELS  raw samples, one bit per lane
//  vote       out  CHANNELS  registered majority decision per lane
//  vote_valid out  1         window filled; vote meaningful
//  vote_stb   out  1         one-cycle pulse: vote updated this cycle
//  rise       out  CHANNELS  one-cycle pulse: lane vote went 0->1
//  fall       out  CHANNELS  one-cycle pulse: lane vote went 1->0
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous, active-high. Reset and
//    clear zero all shift registers, counts, fill counter, and all outputs.
//  - Per lane: WINDOW-bit shift register plus running count, CW=$clog2(WINDOW+1).
//    On sample_en: count_next = count + din - oldest bit; shift din in.
//    Count never exceeds WINDOW and never underflows.
//  - HYSTERESIS=0: vote_next = (count_next >= THRESH_HI).
//  - HYSTERESIS=1: vote_next = 1 if count_next >= THRESH_HI, 0 if
//    count_next <= THRESH_LO, else hold vote.
//  - Latency: sample_en in cycle n -> vote/vote_stb/rise/fall in cycle n+1,
//    reflecting a window that includes the sample from cycle n.
//  - Fill counter counts sample_en, saturates at WINDOW. vote_valid rises in
//    the cycle the WINDOW-th sample's vote appears. It stays high until
//    reset or clear.
//  - vote is computed during fill: empty slots are 0. rise/fall and
//    vote_stb pulse only while vote_valid=1 (incl. the first valid cycle;
//    rise fires there if vote=1).
//  - No sample_en: all state holds; strobes are 0.
//  - clear with sample_en in the same cycle: clear wins, sample discarded.
//  - reset mid-window: state lost, fill restarts from 0.
//  - Elaboration checks ($error): WINDOW<2; THRESH_HI>WINDOW; THRESH_HI==0;
//    HYSTERESIS && THRESH_LO>=THRESH_HI.
// STRUCTURE
//  - Shared package majority_pkg:
//    - MAJ_WINDOW_DEF=8, MAJ_THRESH_HI_DEF=5, MAJ_THRESH_LO_DEF=3;
//    - function cnt_width(window) returns $clog2(window+1).
//  - Sub-module majority_lane holds one lane's shift register, running count,
//    vote register and rise/fall detect. Top generates CHANNELS instances.
//  - Top owns the shared fill counter, vote_valid and vote_stb.
// TESTING
//  1 Reset: reset high 2 cycles, then din=1 with no sample_en for 10 cycles
//    -> vote=0, vote_valid=0, all strobes 0.
//  2 Default 5-of-8: feed 1,1,1,1,0,0,0,0, then 1 -> vote_valid on the 8th
//    sample. vote=0 (count 4). 9th sample: count 4 (oldest 1 drops), vote=0.
//    Then feed 1,1,1,1 -> vote=1 on the 4th of these (count 5), rise pulses
//    once.
//  3 Hysteresis (HYSTERESIS=1, HI=5, LO=3): count path 5->4->3 ->
//    vote 1,1,0; fall pulses only at 3. Path 3->4 -> vote holds 0, no rise.
//  4 Multi-lane (CHANNELS=4): lanes driven 4'b1010 constant for 8 samples
//    -> vote=4'b1010, rise=4'b1010 in the first valid cycle, lanes
//    independent.
//  5 Clear collision: clear and sample_en in the same cycle mid-window
//    -> next cycle count=0, vote=0, vote_valid=0, no strobes; the refill
//    needs a full 8 samples.
//  6 Stall: sample_en gapped (1 every 3 cycles) -> identical vote sequence
//    to ungapped run, vote_stb exactly 1 cycle after each sample_en.

Source files
------------

// File: rtl/majority_filter_pkg.sv
// Shared defaults and helpers for the majority_filter voter and its lanes.
package majority_pkg;

  localparam int MAJ_WINDOW_DEF    = 8;
  localparam int MAJ_THRESH_HI_DEF = 5;
  localparam int MAJ_THRESH_LO_DEF = 3;

  // Width needed to hold a count from 0 up to and including window.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/majority_filter_if.sv
// Sample/decision bundle between the oversampler, the voter and the framing logic.
interface majority_filter_if #(
  parameter int CHANNELS = 1
);
  logic                clear;
  logic                sample_en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] vote;
  logic                vote_valid;
  logic                vote_stb;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (
    output clear, sample_en, din,
    input  vote, vote_valid, vote_stb, rise, fall
  );

  modport slave (
    input  clear, sample_en, din,
    output vote, vote_valid, vote_stb, rise, fall
  );
endinterface

// File: rtl/majority_filter_lane.sv
// One lane: sliding window shift register, running ones count, vote and edge detect.
module majority_lane
  import majority_pkg::*;
#(
  parameter int WINDOW     = MAJ_WINDOW_DEF,
  parameter int THRESH_HI  = MAJ_THRESH_HI_DEF,
  parameter int THRESH_LO  = MAJ_THRESH_LO_DEF,
  parameter bit HYSTERESIS = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample_en,
  input  logic din,
  input  logic valid,
  input  logic valid_next,
  output logic vote,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(WINDOW);
  localparam logic [CW-1:0] HI = CW'(THRESH_HI);
  localparam logic [CW-1:0] LO = CW'(THRESH_LO);

  logic [WINDOW-1:0] shreg;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              vote_next;
  logic              prev_vote;

  // Next count/vote assuming din is shifted in and the oldest bit falls out.
  always_comb begin
    count_next = count;
    if (din && !shreg[WINDOW-1]) begin
      count_next = count + CW'(1);
    end else if (!din && shreg[WINDOW-1]) begin
      count_next = count - CW'(1);
    end
    vote_next = vote;
    if (count_next >= HI) begin
      vote_next = 1'b1;
    end else if (!HYSTERESIS || (count_next <= LO)) begin
      vote_next = 1'b0;
    end
    // Before the window is full the reported vote is treated as 0, so the
    // first valid cycle flags a rise when the lane is already high.
    prev_vote = valid ? vote : 1'b0;
  end

  // Window state advances only on qualified samples; edge strobes last one cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      count <= '0;
      vote  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (sample_en) begin
      shreg <= {shreg[WINDOW-2:0], din};
      count <= count_next;
      vote  <= vote_next;
      rise  <= valid_next && vote_next && !prev_vote;
      fall  <= valid_next && !vote_next && prev_vote;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/majority_filter.sv
// Multi-lane sliding-window majority voter; owns the shared fill tracking and update strobe.
module majority_filter
  import majority_pkg::*;
#(
  parameter int CHANNELS   = 1,
  parameter int WINDOW     = MAJ_WINDOW_DEF,
  parameter int THRESH_HI  = MAJ_THRESH_HI_DEF,
  parameter int THRESH_LO  = MAJ_THRESH_LO_DEF,
  parameter bit HYSTERESIS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  majority_filter_if.slave  bus
);

  localparam int CW = cnt_width(WINDOW);
  localparam logic [CW-1:0] FILL_INIT = CW'(WINDOW);

  if (WINDOW < 2) begin : g_chk_window
    $error("majority_filter: WINDOW must be at least 2");
  end
  if (THRESH_HI > WINDOW) begin : g_chk_hi_range
    $error("majority_filter: THRESH_HI exceeds WINDOW");
  end
  if (THRESH_HI == 0) begin : g_chk_hi_zero
    $error("majority_filter: THRESH_HI must be non-zero");
  end
  if (HYSTERESIS && (THRESH_LO >= THRESH_HI)) begin : g_chk_hyst
    $error("majority_filter: THRESH_LO must be below THRESH_HI with hysteresis");
  end

  // Samples still needed before the window is full; terminal count is zero.
  logic [CW-1:0]       fill_left;
  logic                valid_next;
  logic [CHANNELS-1:0] vote_w;
  logic [CHANNELS-1:0] rise_w;
  logic [CHANNELS-1:0] fall_w;

  // Validity becomes sticky on the sample that fills the window.
  always_comb begin
    valid_next = bus.vote_valid || (bus.sample_en && (fill_left == CW'(1)));
  end

  // Fill down-counter, vote_valid and the per-update strobe.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      fill_left      <= FILL_INIT;
      bus.vote_valid <= 1'b0;
      bus.vote_stb   <= 1'b0;
    end else if (bus.sample_en) begin
      if (fill_left != '0) begin
        fill_left <= fill_left - CW'(1);
      end
      bus.vote_valid <= valid_next;
      bus.vote_stb   <= valid_next;
    end else begin
      bus.vote_stb <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    majority_lane #(
      .WINDOW     (WINDOW),
      .THRESH_HI  (THRESH_HI),
      .THRESH_LO  (THRESH_LO),
      .HYSTERESIS (HYSTERESIS)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clear      (bus.clear),
      .sample_en  (bus.sample_en),
      .din        (bus.din[i]),
      .valid      (bus.vote_valid),
      .valid_next (valid_next),
      .vote       (vote_w[i]),
      .rise       (rise_w[i]),
      .fall       (fall_w[i])
    );
  end

  assign bus.vote = vote_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;

endmodule
